ysyx_220066_dmem_resp: RTL and testbench
========================================

Name: ysyx_220066_dmem_resp

Overview:
Memory-side responder for the core's data-memory port. It accepts one load or store request at a time and services it from an internal 64-bit-wide SRAM array after a programmable latency. It performs byte-lane masking on stores and lane extraction with sign or zero extension on loads, and it flags bad accesses. It sits between the core's load/store unit and the simulated data store, and replaces the combinational DPI memory with a real handshake.

Parameters:
DEPTH, 4096, number of 64-bit words in the array (power of two)
BASE, 64'h8000_0000, byte address of word 0
LATENCY, 2, cycles spent in BUSY after acceptance (minimum 1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_wr  in  1  1 = store, 0 = load
req_op  in  3  MemOp, RV funct3 encoding: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
req_addr  in  64  byte address
req_wdata  in  64  store data, right-aligned (low bytes significant)
resp_valid  out  1  response present
resp_ready  in  1  requester takes the response
resp_rdata  out  64  load result, extended to 64 bits; 0 for stores and errors
resp_err  out  1  access fault for this response

Behaviour:
- Reset (rst==0 at an edge): state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 on the next cycle. The array is not cleared.
- Reset mid-operation: the request is abandoned. A store that has not yet committed is dropped. No response is issued.
- FSM states: IDLE, BUSY, RESP. One request is outstanding at most.
- IDLE: req_ready=1. If req_valid at an edge, latch wr/op/addr/wdata, load the counter with LATENCY-1, and go to BUSY.
- BUSY: req_ready=0. The counter decrements each cycle. At the edge where counter==0:
  - commit the store (if any) to the array;
  - register resp_rdata and resp_err;
  - go to RESP.
  - Acceptance-to-resp_valid latency is exactly LATENCY cycles.
- RESP: resp_valid=1, outputs held stable. At an edge with resp_ready=1, clear resp_valid, clear resp_rdata and resp_err to 0, and go to IDLE. Back-to-back throughput is LATENCY+2 cycles per request.
- req_ready is asserted only in IDLE. A req_valid outside IDLE is ignored; the requester must hold it.
- Address decode:
  - offset = addr - BASE; index = offset[3+log2(DEPTH)-1:3]; lane = addr[2:0].
  - In range iff addr >= BASE and offset < DEPTH*8. Compute this at 64-bit width with no wrap: addr < BASE is out of range.
- Error conditions, any of which sets resp_err=1, forces resp_rdata=0, and suppresses the write:
  - out of range;
  - misaligned: H/HU with addr[0]!=0, W/WU with addr[1:0]!=0, D with addr[2:0]!=0;
  - op==111;
  - a store with op[2]==1.
- Store: byte mask B=0x01, H=0x03, W=0x0F, D=0xFF, shifted left by lane. Data is wdata shifted left by 8*lane. Only masked bytes of word[index] change.
- Load: shift word[index] right by 8*lane, then take the low 8/16/32/64 bits.
  - B/H/W: sign-extend.
  - BU/HU/WU: zero-extend.
  - D: as read.
- Ordering: a load issued after a store's response observes that store, because the commit precedes resp_valid.

Decomposition:
- Package ysyx_220066_mem_pkg: MemOp constants (OP_B..OP_WU), FSM state enum (IDLE/BUSY/RESP), and a function returning the byte-mask from op.
- One sub-module, ysyx_220066_lane_align. It is purely combinational and contains:
  - the misalignment check and error flag;
  - the store mask and shifted data;
  - load extraction with sign/zero extension.
- The parent holds the FSM, the counter, the request latches, and the array.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req_valid=1 -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; no acceptance.
- Store D 0x1122334455667788 @0x80000010, then load D @0x80000010 -> resp_rdata=0x1122334455667788, resp_err=0. resp_valid must rise exactly 2 cycles after each acceptance.
- Store B 0xFF @0x80000013 over that word, then:
  - load D -> 0x11223344FF667788;
  - load B @0x80000013 -> 0xFFFFFFFFFFFFFFFF;
  - load BU -> 0x00000000000000FF.
- Store W 0xDEADBEEF @0x80000002 (misaligned) -> resp_err=1 and resp_rdata=0. A following load D @0x80000000 shows the word unchanged.
- Load @0x7FFFFFF8 and load @BASE+DEPTH*8 -> resp_err=1 for both. A load with op=111 -> resp_err=1.
- Backpressure: keep resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable and req_ready=0. Assert rst=0 during BUSY of a pending store -> that store is not committed, as shown by a later load.

Source files
------------

// File: rtl/ysyx_220066_mem_pkg.sv
// Shared definitions for the data-memory responder: MemOp codes, FSM states,
// request payload and the byte-mask helper.
package ysyx_220066_mem_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_D  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;
    localparam logic [2:0] OP_WU = 3'b110;
    localparam logic [2:0] OP_XX = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic        wr;
        logic [2:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
    } mem_req_t;

    // Unshifted byte-enable for an access size; the illegal op enables nothing.
    function automatic logic [7:0] op_byte_mask(input logic [2:0] op);
        logic [7:0] m;
        if (op == OP_XX) begin
            m = 8'h00;
        end else begin
            case (op[1:0])
                2'b00:   m = 8'h01;
                2'b01:   m = 8'h03;
                2'b10:   m = 8'h0F;
                default: m = 8'hFF;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ysyx_220066_lane_align.sv
// Combinational lane handling: access-fault detection, store lane placement
// and load lane extraction with sign/zero extension.
module ysyx_220066_lane_align
    import ysyx_220066_mem_pkg::*;
(
    input  logic        i_wr,
    input  logic [2:0]  i_op,
    input  logic [2:0]  i_lane,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rword,
    output logic        o_err_c,
    output logic [7:0]  o_wmask_c,
    output logic [63:0] o_wdata_c,
    output logic [63:0] o_rdata_c
);

    logic [5:0]  w_shamt;
    logic [63:0] w_shifted;
    logic        w_misalign;

    assign w_shamt   = {i_lane, 3'b000};
    assign w_shifted = i_rword >> w_shamt;

    // Natural-alignment check per access size.
    always_comb begin
        w_misalign = 1'b0;
        case (i_op)
            OP_H, OP_HU: w_misalign = i_lane[0];
            OP_W, OP_WU: w_misalign = (i_lane[1:0] != 2'b00);
            OP_D:        w_misalign = (i_lane != 3'b000);
            default:     w_misalign = 1'b0;
        endcase
    end

    // Faults that do not depend on the address range.
    assign o_err_c = w_misalign || (i_op == OP_XX) || (i_wr && i_op[2]);

    // Store data and byte enables moved into the addressed lane.
    assign o_wmask_c = op_byte_mask(i_op) << i_lane;
    assign o_wdata_c = i_wdata << w_shamt;

    // Load extraction from the lane-shifted word.
    always_comb begin
        o_rdata_c = 64'd0;
        case (i_op)
            OP_B:    o_rdata_c = {{56{w_shifted[7]}},  w_shifted[7:0]};
            OP_H:    o_rdata_c = {{48{w_shifted[15]}}, w_shifted[15:0]};
            OP_W:    o_rdata_c = {{32{w_shifted[31]}}, w_shifted[31:0]};
            OP_D:    o_rdata_c = w_shifted;
            OP_BU:   o_rdata_c = {56'd0, w_shifted[7:0]};
            OP_HU:   o_rdata_c = {48'd0, w_shifted[15:0]};
            OP_WU:   o_rdata_c = {32'd0, w_shifted[31:0]};
            default: o_rdata_c = 64'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_220066_dmem_resp.sv
// Data-memory responder: single outstanding request, fixed latency, 64-bit
// word array with byte-lane stores and extended loads.
module ysyx_220066_dmem_resp
    import ysyx_220066_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_op,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;

    logic [63:0]      r_mem [DEPTH];
    state_e           r_state;
    state_e           w_next;
    mem_req_t         r_req;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic [63:0]      r_resp_rdata;
    logic             r_resp_err;

    logic [63:0]      w_offset;
    logic             w_in_range;
    logic [IDX_W-1:0] w_index;
    logic [63:0]      w_rword;
    logic             w_align_err;
    logic [7:0]       w_wmask;
    logic [63:0]      w_wdata_sh;
    logic [63:0]      w_rdata;
    logic             w_err;
    logic             w_done;
    logic             w_commit;

    // Address decode; addr < BASE is caught before the subtraction can wrap.
    assign w_offset   = r_req.addr - BASE;
    assign w_in_range = (r_req.addr >= BASE) && (w_offset < SPAN);
    assign w_index    = w_offset[3 +: IDX_W];
    assign w_rword    = r_mem[w_index];

    ysyx_220066_lane_align u_align (
        .i_wr      (r_req.wr),
        .i_op      (r_req.op),
        .i_lane    (r_req.addr[2:0]),
        .i_wdata   (r_req.wdata),
        .i_rword   (w_rword),
        .o_err_c   (w_align_err),
        .o_wmask_c (w_wmask),
        .o_wdata_c (w_wdata_sh),
        .o_rdata_c (w_rdata)
    );

    assign w_err    = !w_in_range || w_align_err;
    assign w_done   = (r_state == ST_BUSY) && (r_cnt == '0);
    // A reset on the commit edge abandons the store.
    assign w_commit = w_done && r_req.wr && !w_err && rst;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid)  w_next = ST_BUSY;
            ST_BUSY: if (r_cnt == '0) w_next = ST_RESP;
            ST_RESP: if (resp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request latch, latency counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_req        <= '0;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_req_ready  <= (w_next == ST_IDLE);
            r_resp_valid <= (w_next == ST_RESP);
            if (r_state == ST_IDLE && req_valid) begin
                r_req.wr    <= req_wr;
                r_req.op    <= req_op;
                r_req.addr  <= req_addr;
                r_req.wdata <= req_wdata;
                r_cnt       <= CNT_W'(LATENCY - 1);
            end else if (r_state == ST_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_done) begin
                r_resp_rdata <= (w_err || r_req.wr) ? 64'd0 : w_rdata;
                r_resp_err   <= w_err;
            end else if (r_state == ST_RESP && resp_ready) begin
                r_resp_rdata <= 64'd0;
                r_resp_err   <= 1'b0;
            end
        end
    end

    // Array write port: only enabled byte lanes change; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 8; i++) begin
                if (w_wmask[i]) begin
                    r_mem[w_index][8*i +: 8] <= w_wdata_sh[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_ysyx_220066_dmem_resp.sv
// Scoreboard bench for the data-memory responder against a byte-addressed model.
module tb_ysyx_220066_dmem_resp;

    localparam logic [63:0] BASE    = 64'h8000_0000;
    localparam int unsigned DEPTH   = 4096;
    localparam int unsigned LATENCY = 2;
    localparam logic [63:0] SPAN    = 64'(DEPTH) * 64'd8;
    localparam int          PERIOD  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_op;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    always #(PERIOD/2) clk = ~clk;

    ysyx_220066_dmem_resp #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    time         tacc_q[$];
    logic [7:0]  mdl [logic [63:0]];
    int          checks   = 0;
    int          failures = 0;
    bit          hold_ready = 1'b0;

    // Reference: byte-addressed memory, access size 2**op[1:0].
    function automatic void mdl_access(input bit wr, input logic [2:0] op,
                                       input logic [63:0] addr, input logic [63:0] wd,
                                       output logic [63:0] rd, output logic er);
        int unsigned sz;
        logic [63:0] v;
        sz = 1 << op[1:0];
        er = (op == 3'b111) || (wr && op[2]) || ((addr % 64'(sz)) != 0)
             || (addr < BASE) || ((addr - BASE) >= SPAN);
        rd = 64'd0;
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < int'(sz); i++) mdl[addr + 64'(i)] = wd[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < int'(sz); i++)
                    v[8*i +: 8] = mdl.exists(addr + 64'(i)) ? mdl[addr + 64'(i)] : 8'h00;
                if (!op[2] && sz < 8 && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
                rd = v;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Requester backpressure: random unless a test holds it low.
    always @(posedge clk) begin
        #1;
        resp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: latency, stability under backpressure, and scoreboard compare.
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [63:0] prev_d = 64'd0;
    logic        prev_e = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        time  t;
        if (rst === 1'b1 && resp_valid === 1'b1) begin
            checks++;
            if (req_ready !== 1'b0) begin
                failures++;
                $display("FAIL ready_in_resp: got %b expected 0", req_ready);
            end
            if (!prev_v) begin
                checks++;
                if (tacc_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected none");
                end else begin
                    t = tacc_q.pop_front();
                    if (($time - t) != time'(LATENCY*PERIOD + PERIOD/2)) begin
                        failures++;
                        $display("FAIL latency: got %0t expected %0t", $time - t,
                                 time'(LATENCY*PERIOD + PERIOD/2));
                    end
                end
            end else if (!prev_r) begin
                checks++;
                if (resp_rdata !== prev_d || resp_err !== prev_e) begin
                    failures++;
                    $display("FAIL stable: got %h/%b expected %h/%b", resp_rdata, resp_err, prev_d, prev_e);
                end
            end
            if (resp_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL orphan_resp: got %h expected no response", resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                        failures++;
                        $display("FAIL %s: got rdata=%h err=%b expected rdata=%h err=%b",
                                 e.name, resp_rdata, resp_err, e.rdata, e.err);
                    end
                end
            end
        end
        prev_v = (rst === 1'b1) && (resp_valid === 1'b1);
        prev_r = resp_ready;
        prev_d = resp_rdata;
        prev_e = resp_err;
    end

    // Drive one request until accepted; optionally queue its expectation.
    task automatic issue(input bit wr, input logic [2:0] op, input logic [63:0] addr,
                         input logic [63:0] wd, input string nm, input bit push,
                         input bit use_k, input logic [63:0] kd, input logic ke);
        bit          rdy;
        int          guard;
        logic [63:0] ed;
        logic        ee;
        exp_t        e;
        @(posedge clk); #1;
        req_valid = 1'b1; req_wr = wr; req_op = op; req_addr = addr; req_wdata = wd;
        guard = 0;
        do begin
            @(negedge clk); rdy = req_ready;
            @(posedge clk); guard++;
        end while (!rdy && guard < 100);
        if (!rdy) begin
            checks++; failures++;
            $display("FAIL accept_timeout_%s: got ready=0 expected 1", nm);
            #1 req_valid = 1'b0;
            return;
        end
        if (push) begin
            mdl_access(wr, op, addr, wd, ed, ee);
            e.rdata = use_k ? kd : ed;
            e.err   = use_k ? ke : ee;
            e.name  = nm;
            exp_q.push_back(e);
            tacc_q.push_back($time);
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk); guard++;
        end
        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete(); tacc_q.delete();
        end
    endtask

    task automatic txn(input bit wr, input logic [2:0] op, input logic [63:0] addr,
                       input logic [63:0] wd, input string nm);
        issue(wr, op, addr, wd, nm, 1'b1, 1'b0, 64'd0, 1'b0);
        drain();
    endtask

    task automatic txn_k(input bit wr, input logic [2:0] op, input logic [63:0] addr,
                         input logic [63:0] wd, input string nm,
                         input logic [63:0] kd, input logic ke);
        issue(wr, op, addr, wd, nm, 1'b1, 1'b1, kd, ke);
        drain();
    endtask

    initial begin
        logic [63:0] a;
        logic [2:0]  op;
        bit          wr;
        int          guard;
        rst = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_op = 3'b011;
        req_addr = BASE; req_wdata = 64'd0; resp_ready = 1'b0;

        // Reset with a request pending: nothing accepted, outputs idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",  64'(req_ready),  64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata,      64'd0);
        chk("rst_resp_err",   64'(resp_err),   64'd0);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_valid", 64'(resp_valid), 64'd0);
        chk("post_rst_ready", 64'(req_ready),  64'd1);

        // Known contents for the window used below and the last word.
        for (int i = 0; i < 32; i++)
            txn(1'b1, 3'b011, BASE + 64'(i*8), {$urandom, $urandom}, "prefill");
        txn(1'b1, 3'b011, BASE + SPAN - 64'd8, {$urandom, $urandom}, "prefill_last");

        txn_k(1'b1, 3'b011, 64'h8000_0010, 64'h1122334455667788, "st_d", 64'd0, 1'b0);
        txn_k(1'b0, 3'b011, 64'h8000_0010, 64'd0, "ld_d", 64'h1122334455667788, 1'b0);
        txn_k(1'b1, 3'b000, 64'h8000_0013, 64'h0000_0000_0000_00FF, "st_b", 64'd0, 1'b0);
        txn_k(1'b0, 3'b011, 64'h8000_0010, 64'd0, "ld_d_merged", 64'h11223344FF667788, 1'b0);
        txn_k(1'b0, 3'b000, 64'h8000_0013, 64'd0, "ld_b_sign", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        txn_k(1'b0, 3'b100, 64'h8000_0013, 64'd0, "ld_bu_zero", 64'h0000_0000_0000_00FF, 1'b0);
        txn_k(1'b1, 3'b010, 64'h8000_0002, 64'hDEADBEEF, "st_w_misalign", 64'd0, 1'b1);
        txn(1'b0, 3'b011, 64'h8000_0000, 64'd0, "ld_d_unchanged");
        txn_k(1'b0, 3'b011, 64'h7FFF_FFF8, 64'd0, "ld_below_base", 64'd0, 1'b1);
        txn_k(1'b0, 3'b011, BASE + SPAN, 64'd0, "ld_past_end", 64'd0, 1'b1);
        txn(1'b0, 3'b011, BASE + SPAN - 64'd8, 64'd0, "ld_last_word");
        txn_k(1'b0, 3'b111, 64'h8000_0000, 64'd0, "ld_op111", 64'd0, 1'b1);
        txn_k(1'b1, 3'b100, 64'h8000_0008, 64'h55, "st_unsigned_op", 64'd0, 1'b1);

        // Backpressure: response held for 5 cycles.
        hold_ready = 1'b1;
        issue(1'b0, 3'b001, 64'h8000_0016, 64'd0, "ld_h_bp", 1'b1, 1'b0, 64'd0, 1'b0);
        guard = 0;
        do begin @(negedge clk); guard++; end while (resp_valid !== 1'b1 && guard < 50);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_ready", 64'(req_ready),  64'd0);
        end
        hold_ready = 1'b0;
        drain();

        // Reset during BUSY of a store: store must be dropped, no response.
        issue(1'b1, 3'b011, 64'h8000_0020, 64'hA5A5_A5A5_5A5A_5A5A, "st_abandon",
              1'b0, 1'b0, 64'd0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(req_ready),  64'd1);
        chk("midrst_valid", 64'(resp_valid), 64'd0);
        repeat (4) @(negedge clk);
        txn(1'b0, 3'b011, 64'h8000_0020, 64'd0, "ld_after_abandon");

        // Randomized mix inside the known window plus range edges.
        for (int n = 0; n < 80; n++) begin
            wr = ($urandom_range(0, 2) == 0);
            op = 3'($urandom_range(0, 7));
            a  = BASE + 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << op[1:0]) - 64'd1);
            case ($urandom_range(0, 15))
                0: a = BASE - 64'd8;
                1: a = BASE + SPAN;
                2: a = BASE + SPAN - 64'd8;
                default: ;
            endcase
            txn(wr, op, a, {$urandom, $urandom}, wr ? "rand_st" : "rand_ld");
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
